issue_ctrl: RTL and testbench
=============================

# issue_ctrl

Issue controller between decode and the execute stage. Uses a per-register scoreboard to hold back instructions whose sources are still being produced. Sequences the pipeline after a taken jump by sending a fetch redirect and discarding wrong-path decode output for a fixed flush window. Drives the execute stage's valid/ready handshake and owns the only path from decode into execute.

## Interface
Parameters:
- MAX_INFLIGHT, 4: maximum number of issued, not-yet-retired register-writing instructions (1..15).
- FLUSH_CYCLES, 2: cycles decode output is discarded after a redirect (1..7).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- dec_valid_i  in  1  decode holds a valid instruction.
- dec_ready_o  out  1  instruction consumed this cycle (issued or discarded).
- dec_rs1_i  in  5  source register 1.
- dec_rs2_i  in  5  source register 2.
- dec_rd_i  in  5  destination register.
- dec_rd_we_i  in  1  instruction writes dec_rd_i.
- iss_valid_o  out  1  to execute valid_i.
- iss_ready_i  in  1  from execute ready_o.
- wb_valid_i  in  1  a register-writing instruction retires this cycle.
- wb_rd_i  in  5  its destination register.
- jump_taken_i  in  1  from execute jump_taken_o (already qualified by the execute handshake).
- jump_addr_i  in  32  from execute jump_addr_o.
- redirect_o  out  1  one-cycle fetch redirect strobe.
- redirect_addr_o  out  32  redirect target; registered.
- flush_o  out  1  wrong-path discard window is active.
- inflight_o  out  4  number of pending writers.
- stall_cnt_o  out  32  stall counter; present only with ISSUE_CTRL_STATS_EN.

## Operation
- **Scoreboard:** pend[r] is a 4-bit counter for r = 1..31. pend[0] is hard-wired to 0.
- **hazard** = (pend[rs1] != 0) | (pend[rs2] != 0).
- **ok** = (state == RUN) & ~hazard & (inflight < MAX_INFLIGHT, or ~(rd_we & rd != 0)).
- **Issue outputs:**
  - iss_valid_o = dec_valid_i & ok.
  - In RUN, dec_ready_o = ok & iss_ready_i.
  - fire = iss_valid_o & iss_ready_i.
- **Increment:** on fire with dec_rd_we_i and dec_rd_i != 0, pend[rd] and inflight increment.
- **Decrement:** on wb_valid_i with wb_rd_i != 0, pend[wb_rd] and inflight decrement.
  - A decrement at 0 is ignored; neither counter goes below 0.
  - Increment and decrement of the same register in the same cycle leaves it unchanged. inflight is likewise unchanged when both events occur.
- **FSM states:**
  - RUN: normal issue.
  - FLUSH: discard window.
- **RUN → FLUSH** on jump_taken_i. At the next edge:
  - redirect_o=1 for exactly one cycle.
  - redirect_addr_o ← jump_addr_i.
  - flush counter ← FLUSH_CYCLES.
- **The jump itself** issues normally in the cycle jump_taken_i is high, including its link-register scoreboard entry.
- **In FLUSH:**
  - flush_o=1 and iss_valid_o=0.
  - dec_ready_o=1, so wrong-path instructions are dropped with no scoreboard effect.
  - The counter decrements each cycle; at 1 → RUN.
- **jump_taken_i during FLUSH** is ignored; it cannot legally occur.
- **Writeback continues** in FLUSH; older instructions still retire.

## Timing
- **Reset values:** pend[*]=0, inflight_o=0, state=RUN, redirect_o=0, redirect_addr_o=0, flush_o=0, stall_cnt_o=0.
- **Outputs during reset:** iss_valid_o=0 and dec_ready_o=0 while rst=0.
- **Issue path:** combinational, zero cycles from dec_valid_i to iss_valid_o.
- **Scoreboard updates** become visible the cycle after the edge. There is no same-cycle writeback bypass: a retiring source unblocks the following cycle.
- **Back-to-back dependence:** back-to-back dependent instructions stall at least until the producer's wb_valid_i edge.
- **Redirect window:**
  - redirect_o is asserted in cycle J+1, where J is the jump_taken_i cycle.
  - flush_o is high in cycles J+1 .. J+FLUSH_CYCLES.
  - First possible issue is in cycle J+FLUSH_CYCLES+1.
- **Reset mid-flush:** returns to RUN with all counters cleared on the next edge; a pending redirect is cancelled.
- **Stall hold:** if iss_ready_i=0, the instruction is held and nothing is counted.

## Configuration
- **ISSUE_CTRL_STATS_EN defined:**
  - stall_cnt_o exists.
  - It increments, wrapping at 2^32, on every cycle with dec_valid_i=1 & state==RUN & ~ok.
  - It resets to 0.
- **Not defined:** the port and counter are absent, and the remaining behaviour is identical.

## Test plan
- **Dependent pair:**
  - Stimulus: issue `rd=5,we=1`, then `rs1=5`.
  - Required: the second is held (iss_valid_o=0) until the cycle after wb_valid_i with wb_rd_i=5, then issues; inflight_o goes 1 → 0.
- **x0 writer:**
  - Stimulus: issue `rd=0,we=1`, then `rs1=0`.
  - Required: no stall; inflight_o stays 0.
- **Jump:**
  - Stimulus: jump_taken_i=1 with jump_addr_i=0x0000_0100, FLUSH_CYCLES=2.
  - Required: redirect_o pulses once in J+1 with redirect_addr_o=0x100. flush_o is high for 2 cycles, and the 2 decode instructions presented are dropped with pend unchanged.
- **Capacity:**
  - Stimulus: 4 writers to r1..r4 with no writeback, MAX_INFLIGHT=4.
  - Required: a 5th writer is held. A non-writer with independent sources still issues. Writeback of r2 lets the 5th issue next cycle.
- **Same-cycle inc/dec:**
  - Stimulus: issue writer r7 while wb_valid_i retires r7, with pend[r7]=1.
  - Required: pend[r7] stays 1 and inflight_o is unchanged.
- **Reset during FLUSH:**
  - Stimulus: assert rst=0 during FLUSH.
  - Required: the next cycle shows flush_o=0, redirect_o=0, inflight_o=0.
  - With ISSUE_CTRL_STATS_EN, stall_cnt_o reads 0.

Source files
------------

// File: rtl/issue_ctrl.sv
// Issue controller: per-register scoreboard gating decode->execute issue, plus a
// redirect/flush sequencer after taken jumps. Optional stall counter under ISSUE_CTRL_STATS_EN.
//
//  state | meaning
//  RUN   | normal issue, scoreboard-gated
//  FLUSH | wrong-path discard window after a redirect
module issue_ctrl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid_i,
    output logic        dec_ready_o,
    input  logic [4:0]  dec_rs1_i,
    input  logic [4:0]  dec_rs2_i,
    input  logic [4:0]  dec_rd_i,
    input  logic        dec_rd_we_i,
    output logic        iss_valid_o,
    input  logic        iss_ready_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        jump_taken_i,
    input  logic [31:0] jump_addr_i,
    output logic        redirect_o,
    output logic [31:0] redirect_addr_o,
    output logic        flush_o,
    output logic [3:0]  inflight_o
`ifdef ISSUE_CTRL_STATS_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [2:0]  flush_cnt, flush_cnt_nxt;
    logic [3:0]  pend [32];
    logic        hazard, writes, ok, fire, inc, dec;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            RUN: begin
                if (jump_taken_i) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = 3'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (flush_cnt == 3'd1) state_nxt = RUN;
                flush_cnt_nxt = flush_cnt - 3'd1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        hazard      = (pend[dec_rs1_i] != 4'd0) | (pend[dec_rs2_i] != 4'd0);
        writes      = dec_rd_we_i & (dec_rd_i != 5'd0);
        ok          = (state == RUN) & ~hazard & ((inflight_o < 4'(MAX_INFLIGHT)) | ~writes);
        iss_valid_o = rst & dec_valid_i & ok;
        dec_ready_o = rst & ((state == FLUSH) | (ok & iss_ready_i));
        fire        = iss_valid_o & iss_ready_i;
        inc         = fire & writes;
        // Retiring a register with no pending writer is ignored so counters never underflow.
        dec         = wb_valid_i & (wb_rd_i != 5'd0) & (pend[wb_rd_i] != 4'd0);
        flush_o     = (state == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= RUN;
            flush_cnt       <= 3'd0;
            redirect_o      <= 1'b0;
            redirect_addr_o <= 32'd0;
            inflight_o      <= 4'd0;
            for (int r = 0; r < 32; r++) pend[r] <= 4'd0;
        end else begin
            state      <= state_nxt;
            flush_cnt  <= flush_cnt_nxt;
            redirect_o <= (state == RUN) & jump_taken_i;
            if ((state == RUN) && jump_taken_i) redirect_addr_o <= jump_addr_i;
            pend[0] <= 4'd0;
            for (int r = 1; r < 32; r++) begin
                if (inc && dec_rd_i == 5'(r) && !(dec && wb_rd_i == 5'(r)))
                    pend[r] <= pend[r] + 4'd1;
                else if (dec && wb_rd_i == 5'(r) && !(inc && dec_rd_i == 5'(r)))
                    pend[r] <= pend[r] - 4'd1;
            end
            case ({inc, dec})
                2'b10:   inflight_o <= inflight_o + 4'd1;
                2'b01:   inflight_o <= inflight_o - 4'd1;
                default: inflight_o <= inflight_o;
            endcase
        end
    end

`ifdef ISSUE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) stall_cnt_o <= 32'd0;
        else if (dec_valid_i && state == RUN && !ok) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: vector table for scoreboard behaviour, hand sequences
// for jump/flush and reset-during-flush.
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid_i, dec_ready_o, dec_rd_we_i;
    logic [4:0]  dec_rs1_i, dec_rs2_i, dec_rd_i, wb_rd_i;
    logic        iss_valid_o, iss_ready_i, wb_valid_i, jump_taken_i;
    logic [31:0] jump_addr_i, redirect_addr_o;
    logic        redirect_o, flush_o;
    logic [3:0]  inflight_o;
`ifdef ISSUE_CTRL_STATS_EN
    logic [31:0] stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    issue_ctrl #(.MAX_INFLIGHT(4), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
        .dec_rd_i(dec_rd_i), .dec_rd_we_i(dec_rd_we_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
        .jump_taken_i(jump_taken_i), .jump_addr_i(jump_addr_i),
        .redirect_o(redirect_o), .redirect_addr_o(redirect_addr_o),
        .flush_o(flush_o), .inflight_o(inflight_o)
`ifdef ISSUE_CTRL_STATS_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [4:0] rs1, rs2, rd;
        logic       we, rdy, wbv;
        logic [4:0] wbr;
        logic       e_iv, e_dr;
        logic [3:0] e_inf;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic rdy,
                         input logic wbv, input logic [4:0] wbr);
        dec_valid_i = dv; dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rd_i = rd;
        dec_rd_we_i = we; iss_ready_i = rdy; wb_valid_i = wbv; wb_rd_i = wbr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           dv  rs1 rs2 rd  we rdy wbv wbr  iv dr inf
        vecs[0]  = '{1, 1,  2,  5,  1, 1, 0, 0,  1, 1, 0};  // producer r5
        vecs[1]  = '{1, 5,  0,  6,  0, 1, 0, 0,  0, 0, 1};  // dependent held
        vecs[2]  = '{1, 5,  0,  6,  0, 1, 1, 5,  0, 0, 1};  // wb r5, no bypass
        vecs[3]  = '{1, 5,  0,  6,  0, 1, 0, 0,  1, 1, 0};  // unblocked next cycle
        vecs[4]  = '{1, 3,  4,  0,  1, 1, 0, 0,  1, 1, 0};  // x0 writer
        vecs[5]  = '{1, 0,  0,  0,  0, 1, 0, 0,  1, 1, 0};  // reads x0, no stall
        vecs[6]  = '{1, 0,  0,  9,  1, 0, 0, 0,  1, 0, 0};  // execute not ready
        vecs[7]  = '{0, 0,  0,  9,  1, 1, 0, 0,  0, 1, 0};  // held writer not counted
        vecs[8]  = '{1, 0,  0,  1,  1, 1, 0, 0,  1, 1, 0};
        vecs[9]  = '{1, 0,  0,  2,  1, 1, 0, 0,  1, 1, 1};
        vecs[10] = '{1, 0,  0,  3,  1, 1, 0, 0,  1, 1, 2};
        vecs[11] = '{1, 0,  0,  4,  1, 1, 0, 0,  1, 1, 3};
        vecs[12] = '{1, 0,  0, 10,  1, 1, 0, 0,  0, 0, 4};  // 5th writer held
        vecs[13] = '{1, 11, 12, 1,  0, 1, 0, 0,  1, 1, 4};  // non-writer issues
        vecs[14] = '{1, 0,  0, 10,  1, 1, 1, 2,  0, 0, 4};  // wb r2
        vecs[15] = '{1, 0,  0, 10,  1, 1, 0, 0,  1, 1, 3};  // 5th issues
        vecs[16] = '{0, 0,  0,  0,  0, 1, 1, 1,  0, 1, 4};
        vecs[17] = '{1, 0,  0,  7,  1, 1, 0, 0,  1, 1, 3};  // pend[7]=1
        vecs[18] = '{0, 0,  0,  0,  0, 1, 1, 3,  0, 1, 4};
        vecs[19] = '{1, 0,  0,  7,  1, 1, 1, 7,  1, 1, 3};  // inc+dec r7
        vecs[20] = '{1, 7,  0,  0,  0, 1, 0, 0,  0, 0, 3};  // r7 still pending
        vecs[21] = '{1, 7,  0,  0,  0, 1, 1, 7,  0, 0, 3};
        vecs[22] = '{1, 7,  0,  0,  0, 1, 0, 0,  1, 1, 2};
        vecs[23] = '{0, 0,  0,  0,  0, 1, 1, 20, 0, 1, 2};  // dec at 0 ignored
        vecs[24] = '{0, 0,  0,  0,  0, 1, 0, 0,  0, 1, 2};

        rst = 1'b0;
        jump_taken_i = 1'b0;
        jump_addr_i  = 32'h0;
        drive(1, 0, 0, 1, 1, 1, 0, 0);
        #2;
        chk("rst_iss_valid", {31'd0, iss_valid_o}, 32'd0);
        chk("rst_dec_ready", {31'd0, dec_ready_o}, 32'd0);
        tick();
        tick();
        chk("rst_inflight", {28'd0, inflight_o}, 32'd0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
        chk("rst_redirect_addr", redirect_addr_o, 32'd0);
`ifdef ISSUE_CTRL_STATS_EN
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
`endif
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].dv, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].we, vecs[i].rdy, vecs[i].wbv, vecs[i].wbr);
            #2;
            chk($sformatf("v%0d_iss_valid", i), {31'd0, iss_valid_o}, {31'd0, vecs[i].e_iv});
            chk($sformatf("v%0d_dec_ready", i), {31'd0, dec_ready_o}, {31'd0, vecs[i].e_dr});
            chk($sformatf("v%0d_inflight", i), {28'd0, inflight_o}, {28'd0, vecs[i].e_inf});
            chk($sformatf("v%0d_flush", i), {31'd0, flush_o}, 32'd0);
            tick();
        end

        // Jump: pending r4, r10; the jump itself writes link r12.
        drive(1, 0, 0, 12, 1, 1, 0, 0);
        jump_taken_i = 1'b1;
        jump_addr_i  = 32'h0000_0100;
        #2;
        chk("j0_iss_valid", {31'd0, iss_valid_o}, 32'd1);
        chk("j0_redirect", {31'd0, redirect_o}, 32'd0);
        tick();
        jump_taken_i = 1'b0;
        jump_addr_i  = 32'hdead_beef;
        drive(1, 0, 0, 13, 1, 1, 0, 0);
        #2;
        chk("j1_redirect", {31'd0, redirect_o}, 32'd1);
        chk("j1_redirect_addr", redirect_addr_o, 32'h0000_0100);
        chk("j1_flush", {31'd0, flush_o}, 32'd1);
        chk("j1_iss_valid", {31'd0, iss_valid_o}, 32'd0);
        chk("j1_dec_ready", {31'd0, dec_ready_o}, 32'd1);
        chk("j1_inflight", {28'd0, inflight_o}, 32'd3);
        tick();
        drive(1, 0, 0, 14, 1, 1, 0, 0);
        #2;
        chk("j2_redirect", {31'd0, redirect_o}, 32'd0);
        chk("j2_flush", {31'd0, flush_o}, 32'd1);
        chk("j2_iss_valid", {31'd0, iss_valid_o}, 32'd0);
        chk("j2_dec_ready", {31'd0, dec_ready_o}, 32'd1);
        chk("j2_redirect_addr", redirect_addr_o, 32'h0000_0100);
        tick();
        drive(1, 13, 14, 0, 0, 1, 0, 0);
        #2;
        chk("j3_flush", {31'd0, flush_o}, 32'd0);
        chk("j3_iss_valid", {31'd0, iss_valid_o}, 32'd1);
        chk("j3_inflight", {28'd0, inflight_o}, 32'd3);
        tick();
        drive(1, 12, 0, 0, 0, 1, 0, 0);
        #2;
        chk("j4_link_hazard", {31'd0, iss_valid_o}, 32'd0);
        tick();

        // Reset while the discard window is active.
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        jump_taken_i = 1'b1;
        jump_addr_i  = 32'h0000_0200;
        tick();
        jump_taken_i = 1'b0;
        drive(1, 0, 0, 15, 1, 1, 0, 0);
        rst = 1'b0;
        #2;
        chk("r1_flush_before", {31'd0, flush_o}, 32'd1);
        chk("r1_iss_valid", {31'd0, iss_valid_o}, 32'd0);
        chk("r1_dec_ready", {31'd0, dec_ready_o}, 32'd0);
        tick();
        rst = 1'b1;
        drive(1, 12, 4, 0, 0, 1, 0, 0);
        #2;
        chk("r2_flush", {31'd0, flush_o}, 32'd0);
        chk("r2_redirect", {31'd0, redirect_o}, 32'd0);
        chk("r2_inflight", {28'd0, inflight_o}, 32'd0);
        chk("r2_redirect_addr", redirect_addr_o, 32'd0);
        chk("r2_pend_cleared", {31'd0, iss_valid_o}, 32'd1);
`ifdef ISSUE_CTRL_STATS_EN
        chk("r2_stall_cnt", stall_cnt_o, 32'd0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
